open_loop_notif_sched: RTL and testbench
========================================

// Module: open_loop_notif_sched
// PURPOSE
//  Per-flow request scheduler for the open-loop TCP app, SEND direction. Consumes TCP RX app
//  notifications (flowid + notif_struct ptr/len), reads the flow's app_cntxt_struct from context
//  RAM and issues one bufsize-long TX request when enough data is available. It bumps curr_reqs,
//  writes the context back and signals flow completion once curr_reqs reaches total_reqs.
//  Sits between the notif NoC deserializer (APP_NOTIF_IF_FBITS) and the TX ptr-IF serializer.
// PARAMETERS
//  FLOWID_W       default FLOWID_W (tcp_pkg)      flow id width / context RAM address width
//  PAYLOAD_PTR_W  default PAYLOAD_PTR_W (tcp_pkg) buffer pointer width (len/ptr are +1 bit)
// PORTS
//  clk                 in   1              single clock
//  rst_n               in   1              asynchronous, active-low reset
//  notif_val           in   1              notification valid
//  notif_flowid        in   FLOWID_W       flow of notification
//  notif_data          in   notif_struct   ptr = next unread byte, len = bytes available
//  notif_rdy           out  1              block accepts notification
//  cntxt_rd_req_val    out  1              context read request
//  cntxt_rd_req_addr   out  FLOWID_W       = latched flowid
//  cntxt_rd_req_rdy    in   1
//  cntxt_rd_resp_val   in   1              context read data valid (any latency >=1)
//  cntxt_rd_resp_data  in   APP_CNTXT_W    app_cntxt_struct
//  cntxt_rd_resp_rdy   out  1
//  cntxt_wr_val        out  1              context write-back
//  cntxt_wr_addr       out  FLOWID_W
//  cntxt_wr_data       out  APP_CNTXT_W
//  cntxt_wr_rdy        in   1
//  tx_req_val          out  1              TX request
//  tx_req_flowid       out  FLOWID_W
//  tx_req_ptr          out  PAYLOAD_PTR_W+1 = notif ptr
//  tx_req_len          out  PAYLOAD_PTR_W+1 = bufsize[PAYLOAD_PTR_W:0]
//  tx_req_rdy          in   1
//  done_val/done_flowid/done_rdy  out/out/in  1/FLOWID_W/1  flow finished all requests
// BEHAVIOUR
//  - Reset: every *_val, notif_rdy and cntxt_rd_resp_rdy = 0; state = IDLE; latches cleared.
//  - All handshakes are val&rdy; outputs are registered and held stable until accepted.
//  - FSM: IDLE -> RD_REQ -> RD_RESP -> DECIDE -> {TX_REQ -> CNTXT_WR -> [DONE] | IDLE}.
//    IDLE: notif_rdy=1; on accept latch flowid/ptr/len.  RD_REQ: hold rd_req until rdy.
//    RD_RESP: resp_rdy=1; latch context.  DECIDE (1 cycle): compare; no outputs.
//    TX_REQ: hold tx_req until rdy.  CNTXT_WR: write ctx with curr_reqs+1.
//    DONE: only if new curr_reqs == total_reqs; hold done_val until rdy; then IDLE.
//  - Issue rule: bufsize != 0 && {zero-ext len} >= bufsize && curr_reqs < total_reqs.
//    Otherwise return to IDLE without TX, write or done (notif dropped; TCP re-notifies).
//  - bufsize > 2^PAYLOAD_PTR_W can never issue (len max = 2^PAYLOAD_PTR_W).
//  - Compares are 32-bit unsigned; curr_reqs+1 cannot wrap (guarded by < total_reqs).
//  - total_reqs == 0: never issues, never signals done.
//  - TX always precedes the write; the write completes before the next notification is accepted.
//    Single request in flight, so no read-after-write hazard on context RAM.
//  - should_copy is passed through unchanged in the write-back.
//  - Min latency notif accept -> tx_req_val: 4 cycles with 1-cycle RAM and rdy=1.
//  - rst_n mid-operation: FSM to IDLE immediately; a pending TX or write is abandoned.
// CONFIGURATION
//  OPEN_LOOP_SCHED_STATS_EN defined: adds outputs stat_tx_reqs[31:0] (+1 per accepted TX).
//    Also adds stat_drops[31:0] (+1 per notif dropped at DECIDE); both reset to 0 and saturate.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  open_loop_pkg: app_cntxt_struct, notif_struct, FBITS constants, and a new sched_state_e enum.
//  Also add a tx_req_struct {flowid, ptr, len} to the package.
//  No sub-module; FSM + datapath in one file. Stats counters are inline under the macro.
// TESTING
//  1 ctx{total=3,bufsize=64,curr=0}, notif len=100 ptr=0x10 -> tx{ptr=0x10,len=64}.
//    Then write curr=1; no done.
//  2 ctx curr=2,total=3, notif len=64 -> tx issued, write curr=3, done_val with flowid.
//  3 notif len=63 bufsize=64 -> no tx/write/done; notif_rdy back at 1 within 4 cycles.
//  4 ctx curr=3,total=3 or bufsize=0 -> dropped, no outputs (stat_drops+1 if STATS_EN).
//  5 tx_req_rdy low 10 cycles -> tx fields stable, no ctx write, notif_rdy stays 0 throughout.
//  6 assert rst_n=0 during TX_REQ -> all vals 0 same cycle; next notif processes normally.

Source files
------------

// File: rtl/open_loop_notif_sched_pkg.sv
// Shared types for the open-loop SEND-direction request scheduler: app context, notification,
// TX request record, FSM state encoding and the request-issue rule.
package open_loop_notif_sched_pkg;

   localparam int OL_FLOWID_W      = 6;
   localparam int OL_PAYLOAD_PTR_W = 10;

   typedef struct packed {
      logic [OL_PAYLOAD_PTR_W:0] ptr;
      logic [OL_PAYLOAD_PTR_W:0] len;
   } notif_struct;

   typedef struct packed {
      logic        should_copy;
      logic [31:0] total_reqs;
      logic [31:0] curr_reqs;
      logic [31:0] bufsize;
   } app_cntxt_struct;

   typedef struct packed {
      logic [OL_FLOWID_W-1:0]    flowid;
      logic [OL_PAYLOAD_PTR_W:0] ptr;
      logic [OL_PAYLOAD_PTR_W:0] len;
   } tx_req_struct;

   localparam int APP_CNTXT_W        = $bits(app_cntxt_struct);
   localparam int APP_NOTIF_IF_FBITS = OL_FLOWID_W + $bits(notif_struct);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_REQ   = 3'd1,
      ST_RD_RESP  = 3'd2,
      ST_DECIDE   = 3'd3,
      ST_TX_REQ   = 3'd4,
      ST_CNTXT_WR = 3'd5,
      ST_DONE     = 3'd6
   } sched_state_e;

   // Enough unread data for one full buffer and the flow still owes requests.
   function automatic logic sched_issue_ok(input app_cntxt_struct c,
                                           input logic [OL_PAYLOAD_PTR_W:0] len);
      logic [31:0] len_ext;
      len_ext = 32'(len);
      return (c.bufsize != 32'd0) && (len_ext >= c.bufsize) && (c.curr_reqs < c.total_reqs);
   endfunction

endpackage

// File: rtl/open_loop_notif_sched.sv
// Per-flow TX request scheduler: notif -> context read -> decide -> TX req -> write-back -> done.
// Optional OPEN_LOOP_SCHED_STATS_EN adds saturating stat_tx_reqs / stat_drops counters.
module open_loop_notif_sched
   import open_loop_notif_sched_pkg::*;
#(
   parameter int FLOWID_W      = OL_FLOWID_W,
   parameter int PAYLOAD_PTR_W = OL_PAYLOAD_PTR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   notif_val,
   input  logic [FLOWID_W-1:0]    notif_flowid,
   input  notif_struct            notif_data,
   output logic                   notif_rdy,
   output logic                   cntxt_rd_req_val,
   output logic [FLOWID_W-1:0]    cntxt_rd_req_addr,
   input  logic                   cntxt_rd_req_rdy,
   input  logic                   cntxt_rd_resp_val,
   input  logic [APP_CNTXT_W-1:0] cntxt_rd_resp_data,
   output logic                   cntxt_rd_resp_rdy,
   output logic                   cntxt_wr_val,
   output logic [FLOWID_W-1:0]    cntxt_wr_addr,
   output logic [APP_CNTXT_W-1:0] cntxt_wr_data,
   input  logic                   cntxt_wr_rdy,
   output logic                   tx_req_val,
   output logic [FLOWID_W-1:0]    tx_req_flowid,
   output logic [PAYLOAD_PTR_W:0] tx_req_ptr,
   output logic [PAYLOAD_PTR_W:0] tx_req_len,
   input  logic                   tx_req_rdy,
   output logic                   done_val,
   output logic [FLOWID_W-1:0]    done_flowid,
   input  logic                   done_rdy
`ifdef OPEN_LOOP_SCHED_STATS_EN
   ,
   output logic [31:0]            stat_tx_reqs,
   output logic [31:0]            stat_drops
`endif
);

   sched_state_e          state_q, state_d;
   logic [FLOWID_W-1:0]   flowid_q, flowid_d;
   notif_struct           notif_q, notif_d;
   app_cntxt_struct       cntxt_q, cntxt_d;
   tx_req_struct          tx_q, tx_d;
   logic                  notif_rdy_q, rd_req_val_q, resp_rdy_q;
   logic                  wr_val_q, tx_val_q, done_val_q;
   logic                  issue_s;

   assign issue_s = sched_issue_ok(cntxt_q, notif_q.len);

   // Next-state and latch updates; outputs are flopped from state_d below.
   always_comb begin
      state_d  = state_q;
      flowid_d = flowid_q;
      notif_d  = notif_q;
      cntxt_d  = cntxt_q;
      tx_d     = tx_q;
      case (state_q)
         ST_IDLE: begin
            if (notif_val && notif_rdy_q) begin
               state_d  = ST_RD_REQ;
               flowid_d = notif_flowid;
               notif_d  = notif_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            if (rd_req_val_q && cntxt_rd_req_rdy) state_d = ST_RD_RESP;
            else                                  state_d = ST_RD_REQ;
         end
         ST_RD_RESP: begin
            if (resp_rdy_q && cntxt_rd_resp_val) begin
               cntxt_d = app_cntxt_struct'(cntxt_rd_resp_data);
               state_d = ST_DECIDE;
            end else begin
               state_d = ST_RD_RESP;
            end
         end
         ST_DECIDE: begin
            // The increment cannot wrap: issue already requires curr_reqs < total_reqs.
            if (issue_s) begin
               state_d           = ST_TX_REQ;
               cntxt_d.curr_reqs = cntxt_q.curr_reqs + 32'd1;
               tx_d.flowid       = flowid_q;
               tx_d.ptr          = notif_q.ptr;
               tx_d.len          = cntxt_q.bufsize[OL_PAYLOAD_PTR_W:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TX_REQ: begin
            if (tx_val_q && tx_req_rdy) state_d = ST_CNTXT_WR;
            else                        state_d = ST_TX_REQ;
         end
         ST_CNTXT_WR: begin
            if (wr_val_q && cntxt_wr_rdy) begin
               if (cntxt_q.curr_reqs == cntxt_q.total_reqs) state_d = ST_DONE;
               else                                         state_d = ST_IDLE;
            end else begin
               state_d = ST_CNTXT_WR;
            end
         end
         ST_DONE: begin
            if (done_val_q && done_rdy) state_d = ST_IDLE;
            else                        state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latched transaction data and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         flowid_q     <= '0;
         notif_q      <= '0;
         cntxt_q      <= '0;
         tx_q         <= '0;
         notif_rdy_q  <= 1'b0;
         rd_req_val_q <= 1'b0;
         resp_rdy_q   <= 1'b0;
         tx_val_q     <= 1'b0;
         wr_val_q     <= 1'b0;
         done_val_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         flowid_q     <= flowid_d;
         notif_q      <= notif_d;
         cntxt_q      <= cntxt_d;
         tx_q         <= tx_d;
         notif_rdy_q  <= (state_d == ST_IDLE);
         rd_req_val_q <= (state_d == ST_RD_REQ);
         resp_rdy_q   <= (state_d == ST_RD_RESP);
         tx_val_q     <= (state_d == ST_TX_REQ);
         wr_val_q     <= (state_d == ST_CNTXT_WR);
         done_val_q   <= (state_d == ST_DONE);
      end
   end

   assign notif_rdy         = notif_rdy_q;
   assign cntxt_rd_req_val  = rd_req_val_q;
   assign cntxt_rd_req_addr = flowid_q;
   assign cntxt_rd_resp_rdy = resp_rdy_q;
   assign cntxt_wr_val      = wr_val_q;
   assign cntxt_wr_addr     = flowid_q;
   assign cntxt_wr_data     = cntxt_q;
   assign tx_req_val        = tx_val_q;
   assign tx_req_flowid     = tx_q.flowid;
   assign tx_req_ptr        = tx_q.ptr;
   assign tx_req_len        = tx_q.len;
   assign done_val          = done_val_q;
   assign done_flowid       = flowid_q;

`ifdef OPEN_LOOP_SCHED_STATS_EN
   logic [31:0] stat_tx_q, stat_drop_q;

   // Saturating counters for accepted TX requests and notifications dropped at decide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_tx_q   <= 32'd0;
         stat_drop_q <= 32'd0;
      end else begin
         if (tx_val_q && tx_req_rdy && (stat_tx_q != 32'hFFFF_FFFF))
            stat_tx_q <= stat_tx_q + 32'd1;
         else
            stat_tx_q <= stat_tx_q;
         if ((state_q == ST_DECIDE) && !issue_s && (stat_drop_q != 32'hFFFF_FFFF))
            stat_drop_q <= stat_drop_q + 32'd1;
         else
            stat_drop_q <= stat_drop_q;
      end
   end

   assign stat_tx_reqs = stat_tx_q;
   assign stat_drops   = stat_drop_q;
`endif

endmodule

// File: tb/tb_open_loop_notif_sched.sv
// Self-checking bench: context RAM + random ready stalls around the scheduler, checked
// per notification against a flow-level model of the issue/done rules.
module tb_open_loop_notif_sched;
   import open_loop_notif_sched_pkg::*;

   localparam int FW    = OL_FLOWID_W;
   localparam int PW    = OL_PAYLOAD_PTR_W;
   localparam int NFLOW = 8;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   notif_val;
   logic [FW-1:0]          notif_flowid;
   notif_struct            notif_data;
   logic                   notif_rdy;
   logic                   cntxt_rd_req_val;
   logic [FW-1:0]          cntxt_rd_req_addr;
   logic                   cntxt_rd_req_rdy;
   logic                   cntxt_rd_resp_val;
   logic [APP_CNTXT_W-1:0] cntxt_rd_resp_data;
   logic                   cntxt_rd_resp_rdy;
   logic                   cntxt_wr_val;
   logic [FW-1:0]          cntxt_wr_addr;
   logic [APP_CNTXT_W-1:0] cntxt_wr_data;
   logic                   cntxt_wr_rdy;
   logic                   tx_req_val;
   logic [FW-1:0]          tx_req_flowid;
   logic [PW:0]            tx_req_ptr;
   logic [PW:0]            tx_req_len;
   logic                   tx_req_rdy;
   logic                   done_val;
   logic [FW-1:0]          done_flowid;
   logic                   done_rdy;
`ifdef OPEN_LOOP_SCHED_STATS_EN
   logic [31:0]            stat_tx_reqs, stat_drops;
`endif

   always #5 clk = ~clk;

   open_loop_notif_sched dut (
      .clk(clk), .rst_n(rst_n),
      .notif_val(notif_val), .notif_flowid(notif_flowid), .notif_data(notif_data),
      .notif_rdy(notif_rdy),
      .cntxt_rd_req_val(cntxt_rd_req_val), .cntxt_rd_req_addr(cntxt_rd_req_addr),
      .cntxt_rd_req_rdy(cntxt_rd_req_rdy),
      .cntxt_rd_resp_val(cntxt_rd_resp_val), .cntxt_rd_resp_data(cntxt_rd_resp_data),
      .cntxt_rd_resp_rdy(cntxt_rd_resp_rdy),
      .cntxt_wr_val(cntxt_wr_val), .cntxt_wr_addr(cntxt_wr_addr),
      .cntxt_wr_data(cntxt_wr_data), .cntxt_wr_rdy(cntxt_wr_rdy),
      .tx_req_val(tx_req_val), .tx_req_flowid(tx_req_flowid), .tx_req_ptr(tx_req_ptr),
      .tx_req_len(tx_req_len), .tx_req_rdy(tx_req_rdy),
      .done_val(done_val), .done_flowid(done_flowid), .done_rdy(done_rdy)
`ifdef OPEN_LOOP_SCHED_STATS_EN
      , .stat_tx_reqs(stat_tx_reqs), .stat_drops(stat_drops)
`endif
   );

   app_cntxt_struct ram   [2**FW];
   app_cntxt_struct model [2**FW];
   tx_req_struct    tx_obs[$];
   app_cntxt_struct wr_obs[$];
   logic [FW-1:0]   wr_addr_obs[$];
   logic [FW-1:0]   done_obs[$];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_tx = 0;
   int   exp_drops = 0;
   logic stall_en = 1'b0;
   logic hold_tx = 1'b0;
   logic rd_fire = 1'b0, resp_fire = 1'b0;
   logic [FW-1:0] rd_addr_s = '0, pend_addr = '0;
   logic pend = 1'b0;
   int   pend_cnt = 0;

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic rnd_rdy();
      if (stall_en) return ($urandom_range(0, 3) != 0);
      else          return 1'b1;
   endfunction

   // Observe handshakes at negedge (inputs change only just after posedge).
   always @(negedge clk) begin
      rd_fire   = cntxt_rd_req_val && cntxt_rd_req_rdy;
      rd_addr_s = cntxt_rd_req_addr;
      resp_fire = cntxt_rd_resp_val && cntxt_rd_resp_rdy;
      if (tx_req_val && tx_req_rdy)
         tx_obs.push_back('{flowid: tx_req_flowid, ptr: tx_req_ptr, len: tx_req_len});
      if (cntxt_wr_val && cntxt_wr_rdy) begin
         wr_obs.push_back(app_cntxt_struct'(cntxt_wr_data));
         wr_addr_obs.push_back(cntxt_wr_addr);
         ram[cntxt_wr_addr] = app_cntxt_struct'(cntxt_wr_data);
      end
      if (done_val && done_rdy) done_obs.push_back(done_flowid);
   end

   // Ready stalls and a context RAM with 1..3 cycle read latency.
   always @(posedge clk) begin
      #1;
      tx_req_rdy       = hold_tx ? 1'b0 : rnd_rdy();
      cntxt_rd_req_rdy = rnd_rdy();
      cntxt_wr_rdy     = rnd_rdy();
      done_rdy         = rnd_rdy();
      if (!rst_n) begin
         cntxt_rd_resp_val = 1'b0;
         pend = 1'b0;
      end else begin
         if (resp_fire) cntxt_rd_resp_val = 1'b0;
         if (rd_fire) begin
            pend      = 1'b1;
            pend_cnt  = stall_en ? int'($urandom_range(0, 2)) : 0;
            pend_addr = rd_addr_s;
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               cntxt_rd_resp_val  = 1'b1;
               cntxt_rd_resp_data = ram[pend_addr];
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
      end
   end

   task automatic set_ctx(input int f, input logic sc, input int total, input int curr,
                          input int bufsize);
      app_cntxt_struct c;
      c.should_copy = sc;
      c.total_reqs  = 32'(total);
      c.curr_reqs   = 32'(curr);
      c.bufsize     = 32'(bufsize);
      ram[f]   = c;
      model[f] = c;
   endtask

   task automatic send_notif(input logic [FW-1:0] f, input logic [PW:0] p, input logic [PW:0] l);
      logic acc;
      acc = 1'b0;
      @(posedge clk); #1;
      notif_val = 1'b1; notif_flowid = f; notif_data.ptr = p; notif_data.len = l;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (notif_rdy) begin acc = 1'b1; break; end
      end
      chk_eq("notif_accept", 128'(acc), 128'd1);
      @(posedge clk); #1;
      notif_val = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cyc++;
         if (notif_rdy) break;
      end
      chk_eq("back_to_idle", 128'(notif_rdy), 128'd1);
   endtask

   task automatic wait_tx_val();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_req_val) break;
      end
      chk_eq("tx_val_seen", 128'(tx_req_val), 128'd1);
   endtask

   task automatic clear_obs();
      tx_obs.delete(); wr_obs.delete(); wr_addr_obs.delete(); done_obs.delete();
   endtask

   // Flow-level expectation for one completed notification.
   task automatic check_model(input logic [FW-1:0] f, input logic [PW:0] p, input logic [PW:0] l);
      app_cntxt_struct c, nc;
      longint avail, bsz, tot, cur;
      logic iss, dn;
      c     = model[f];
      avail = longint'(l);
      bsz   = longint'(c.bufsize);
      tot   = longint'(c.total_reqs);
      cur   = longint'(c.curr_reqs);
      iss   = (bsz > 0) && (avail >= bsz) && (cur < tot);
      dn    = iss && (cur + 1 == tot);
      chk_eq("tx_count", 128'(tx_obs.size()), iss ? 128'd1 : 128'd0);
      chk_eq("wr_count", 128'(wr_obs.size()), iss ? 128'd1 : 128'd0);
      chk_eq("done_count", 128'(done_obs.size()), dn ? 128'd1 : 128'd0);
      if (iss) begin
         nc = c;
         nc.curr_reqs = 32'(cur + 1);
         model[f] = nc;
         exp_tx++;
         if (tx_obs.size() > 0) begin
            chk_eq("tx_flowid", 128'(tx_obs[0].flowid), 128'(f));
            chk_eq("tx_ptr", 128'(tx_obs[0].ptr), 128'(p));
            chk_eq("tx_len", 128'(tx_obs[0].len), 128'(bsz % 2048));
         end
         if (wr_obs.size() > 0) begin
            chk_eq("wr_addr", 128'(wr_addr_obs[0]), 128'(f));
            chk_eq("wr_data", 128'(wr_obs[0]), 128'(nc));
         end
         if (dn && done_obs.size() > 0) chk_eq("done_flowid", 128'(done_obs[0]), 128'(f));
      end else begin
         exp_drops++;
      end
      clear_obs();
   endtask

   task automatic run_one(input logic [FW-1:0] f, input logic [PW:0] p, input logic [PW:0] l);
      int cyc;
      send_notif(f, p, l);
      wait_idle(cyc);
      check_model(f, p, l);
   endtask

   initial begin
      int lat, cyc, f, total, bs, l;
      tx_req_struct held;

      rst_n = 1'b0; notif_val = 1'b0; notif_flowid = '0; notif_data = '0;
      cntxt_rd_req_rdy = 1'b1; cntxt_rd_resp_val = 1'b0; cntxt_rd_resp_data = '0;
      cntxt_wr_rdy = 1'b1; tx_req_rdy = 1'b1; done_rdy = 1'b1;
      for (int i = 0; i < 2**FW; i++) set_ctx(i, 1'b0, 0, 0, 0);
      #12;
      chk_eq("rst_notif_rdy", 128'(notif_rdy), 128'd0);
      chk_eq("rst_vals", 128'({cntxt_rd_req_val, cntxt_rd_resp_rdy, cntxt_wr_val, tx_req_val,
                               done_val}), 128'd0);
      @(negedge clk); #1 rst_n = 1'b1;

      // 1: first request of a 3-request flow, minimum latency
      set_ctx(1, 1'b1, 3, 0, 64);
      send_notif(6'd1, 11'h10, 11'd100);
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         lat++;
         if (tx_req_val) break;
      end
      chk_eq("t1_latency", 128'(lat), 128'd4);
      wait_idle(cyc);
      check_model(6'd1, 11'h10, 11'd100);

      // 2: last request -> done
      set_ctx(1, 1'b1, 3, 2, 64);
      run_one(6'd1, 11'h20, 11'd64);

      // 3: one byte short -> drop, quick return to idle
      set_ctx(2, 1'b0, 3, 0, 64);
      send_notif(6'd2, 11'h0, 11'd63);
      wait_idle(cyc);
      chk_eq("t3_idle_within_4", 128'(cyc <= 4), 128'd1);
      check_model(6'd2, 11'h0, 11'd63);

      // 4: exhausted flow and zero bufsize both drop
      run_one(6'd1, 11'h30, 11'd500);
      set_ctx(3, 1'b1, 5, 0, 0);
      run_one(6'd3, 11'h40, 11'd500);
      set_ctx(6, 1'b0, 0, 0, 16);
      run_one(6'd6, 11'h40, 11'd500);
`ifdef OPEN_LOOP_SCHED_STATS_EN
      chk_eq("t4_stat_drops", 128'(stat_drops), 128'(exp_drops));
`endif

      // 5: TX backpressure holds request stable, no write, no new notif
      set_ctx(4, 1'b1, 5, 1, 100);
      hold_tx = 1'b1;
      send_notif(6'd4, 11'h155, 11'd200);
      wait_tx_val();
      held = '{flowid: tx_req_flowid, ptr: tx_req_ptr, len: tx_req_len};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_eq("t5_tx_stable", 128'({tx_req_val, tx_req_flowid, tx_req_ptr, tx_req_len}),
                128'({1'b1, held}));
         chk_eq("t5_quiet", 128'({cntxt_wr_val, notif_rdy}), 128'd0);
      end
      hold_tx = 1'b0;
      wait_idle(cyc);
      check_model(6'd4, 11'h155, 11'd200);

      // 6: reset during TX_REQ abandons the request
      set_ctx(5, 1'b0, 2, 0, 32);
      hold_tx = 1'b1;
      send_notif(6'd5, 11'h7, 11'd40);
      wait_tx_val();
      @(negedge clk); #1 rst_n = 1'b0;
      #1;
      chk_eq("t6_vals_in_reset", 128'({tx_req_val, cntxt_wr_val, cntxt_rd_req_val, done_val,
                                       notif_rdy}), 128'd0);
      hold_tx = 1'b0;
      clear_obs();
      exp_tx = 0; exp_drops = 0;
      @(negedge clk); #1 rst_n = 1'b1;
      run_one(6'd5, 11'h7, 11'd40);

      // Randomised traffic with ready stalls and variable RAM latency
      stall_en = 1'b1;
      for (int i = 0; i < NFLOW; i++) begin
         total = int'($urandom_range(0, 4));
         set_ctx(i, 1'($urandom_range(0, 1)), total, int'($urandom_range(0, total)),
                 int'($urandom_range(1, 300)));
      end
      for (int it = 0; it < 150; it++) begin
         f = int'($urandom_range(0, NFLOW - 1));
         if (model[f].curr_reqs >= model[f].total_reqs && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 5))
               0:       bs = 0;
               1:       bs = 1;
               2:       bs = 1024;
               3:       bs = 1025;
               default: bs = int'($urandom_range(1, 1024));
            endcase
            total = int'($urandom_range(0, 4));
            set_ctx(f, 1'($urandom_range(0, 1)), total, int'($urandom_range(0, total)), bs);
         end
         bs = int'(model[f].bufsize);
         if ($urandom_range(0, 1) == 1) l = bs + int'($urandom_range(0, 2)) - 1;
         else                           l = int'($urandom_range(0, 1024));
         if (l < 0)    l = 0;
         if (l > 1024) l = 1024;
         run_one(FW'(f), 11'($urandom_range(0, 2047)), 11'(l));
      end
`ifdef OPEN_LOOP_SCHED_STATS_EN
      chk_eq("stat_tx_reqs", 128'(stat_tx_reqs), 128'(exp_tx));
      chk_eq("stat_drops", 128'(stat_drops), 128'(exp_drops));
`endif
      for (int i = 0; i < NFLOW; i++) chk_eq("ram_final", 128'(ram[i]), 128'(model[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
